// File: rtl/seg_pkg.sv
// Segment encodings shared by the seven-segment display path.
// Codes are gfedcba with 1 = segment lit; cathode drivers invert them.
package seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h00;

    // Element h holds the code for hex value h.
    localparam logic [15:0][6:0] SEG_CODE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic seg_t hex_to_seg(input logic [3:0] hex);
        return SEG_CODE[hex];
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// Hex to active-low cathode decoder with a blanking override.
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       blank,
    output seg_t       seg_n
);

    always_comb begin
        seg_n = blank ? ~SEG_BLANK : ~hex_to_seg(hex);
    end

endmodule

// File: rtl/seven_segment_mux.sv
// Time-multiplexed common-anode display driver with frame-boundary reloads.
// Define SEVEN_SEG_LEADING_ZERO_BLANK_EN to suppress leading zeros.
module seven_segment_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    output logic                    pending,
    output logic                    frame_tick,
    output logic                    C1,
    output logic                    C2,
    output logic                    C3,
    output logic                    C4,
    output logic                    C5,
    output logic                    C6,
    output logic                    C7,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   anode
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(REFRESH_DIV - 1);

    logic [4*NUM_DIGITS-1:0] stg_digits, sh_digits;
    logic [NUM_DIGITS-1:0]   stg_dp, sh_dp;
    logic [NUM_DIGITS-1:0]   stg_en, sh_en;
    logic [NUM_DIGITS-1:0]   lz_next, lz_mask;
    logic [CW-1:0]           div_cnt;
    logic [IW-1:0]           idx;
    seg_t                    seg_n, seg_q;

    logic tc, boundary, blank;
    logic [3:0] sel_hex;

    assign tc       = (div_cnt == LAST_CNT);
    assign boundary = tc && (idx == LAST_IDX);

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    // Mask is built from staging so it lands in the same cycle as the shadow copy.
    // Disabled digits are already dark and do not end the leading-zero run.
    always_comb begin
        logic run;
        run     = 1'b1;
        lz_next = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (stg_en[i]) begin
                if (run && (stg_digits[4*i +: 4] == 4'h0) && !stg_dp[i])
                    lz_next[i] = 1'b1;
                else
                    run = 1'b0;
            end
        end
    end
`else
    assign lz_next = '0;
`endif

    assign sel_hex = sh_digits[4*int'(idx) +: 4];
    assign blank   = ~sh_en[idx] | lz_mask[idx];

    seg_decoder u_dec (
        .hex   (sel_hex),
        .blank (blank),
        .seg_n (seg_n)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stg_digits <= '0;
            stg_dp     <= '0;
            stg_en     <= '0;
            sh_digits  <= '0;
            sh_dp      <= '0;
            sh_en      <= '0;
            lz_mask    <= '0;
            pending    <= 1'b0;
            div_cnt    <= '0;
            idx        <= '0;
            frame_tick <= 1'b0;
            anode      <= '1;
            seg_q      <= '1;
            dp_n       <= 1'b1;
        end else begin
            if (tc) begin
                div_cnt <= '0;
                idx     <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            frame_tick <= boundary;

            // Shadow takes the old staging even if a new load lands this cycle.
            if (boundary && pending) begin
                sh_digits <= stg_digits;
                sh_dp     <= stg_dp;
                sh_en     <= stg_en;
                lz_mask   <= lz_next;
            end
            if (load) begin
                stg_digits <= digits;
                stg_dp     <= dp;
                stg_en     <= digit_en;
            end
            pending <= load | (pending & ~boundary);

            anode <= ~(NUM_DIGITS'(1) << idx);
            seg_q <= seg_n;
            dp_n  <= blank | ~sh_dp[idx];
        end
    end

    assign {C7, C6, C5, C4, C3, C2, C1} = seg_q;

endmodule

// File: tb/tb_seven_segment_mux.sv
// Directed bench for seven_segment_mux with NUM_DIGITS=8, REFRESH_DIV=4.
module tb_seven_segment_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] digits;
    logic [7:0]  dp, digit_en;
    logic        load;
    logic        pending, frame_tick;
    logic        C1, C2, C3, C4, C5, C6, C7, dp_n;
    logic [7:0]  anode;

    int passed = 0;
    int total  = 0;

    logic [7:0] cap_an  [8];
    logic [6:0] cap_seg [8];
    logic       cap_dp  [8];

    seven_segment_mux #(.NUM_DIGITS(8), .REFRESH_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .digits(digits), .dp(dp), .digit_en(digit_en),
        .load(load), .pending(pending), .frame_tick(frame_tick),
        .C1(C1), .C2(C2), .C3(C3), .C4(C4), .C5(C5), .C6(C6), .C7(C7),
        .dp_n(dp_n), .anode(anode)
    );

    always #5 clk = ~clk;

    // Expected cathodes in {C7..C1} order for a lit hex value.
    function automatic logic [6:0] exp_seg(input logic [3:0] h);
        logic [6:0] lit;
        case (h)
            4'h0: lit = 7'h3F; 4'h1: lit = 7'h06; 4'h2: lit = 7'h5B; 4'h3: lit = 7'h4F;
            4'h4: lit = 7'h66; 4'h5: lit = 7'h6D; 4'h6: lit = 7'h7D; 4'h7: lit = 7'h07;
            4'h8: lit = 7'h7F; 4'h9: lit = 7'h6F; 4'hA: lit = 7'h77; 4'hB: lit = 7'h7C;
            4'hC: lit = 7'h39; 4'hD: lit = 7'h5E; 4'hE: lit = 7'h79; default: lit = 7'h71;
        endcase
        return ~lit;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (frame_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Starting on a frame_tick sample, record the first lit cycle of each digit.
    task automatic capture();
        for (int d = 0; d < 8; d++) begin
            tick();
            cap_an[d]  = anode;
            cap_seg[d] = {C7, C6, C5, C4, C3, C2, C1};
            cap_dp[d]  = dp_n;
            repeat (3) tick();
        end
    endtask

    task automatic do_load(input logic [31:0] v, input logic [7:0] en, input logic [7:0] p);
        digits = v; digit_en = en; dp = p; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b0; digits = '0; dp = '0; digit_en = '0;
        repeat (3) tick();
        total++; if (anode !== 8'hFF) $display("FAIL reset_anode got %h want ff", anode); else passed++;
        total++; if ({C7,C6,C5,C4,C3,C2,C1} !== 7'h7F) $display("FAIL reset_seg got %h want 7f", {C7,C6,C5,C4,C3,C2,C1}); else passed++;
        total++; if (dp_n !== 1'b1) $display("FAIL reset_dp_n got %b want 1", dp_n); else passed++;
        total++; if (frame_tick !== 1'b0) $display("FAIL reset_frame_tick got %b want 0", frame_tick); else passed++;
        total++; if (pending !== 1'b0) $display("FAIL reset_pending got %b want 0", pending); else passed++;
    endtask

    task automatic test_scan();
        logic [7:0] exp_an;
        rst_n = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            tick();
            exp_an = ~(8'h01 << (((e - 1) / 4) % 8));
            total++; if (anode !== exp_an) $display("FAIL scan_anode e=%0d got %h want %h", e, anode, exp_an); else passed++;
            total++; if (frame_tick !== (e == 32)) $display("FAIL scan_frame_tick e=%0d got %b want %b", e, frame_tick, (e == 32)); else passed++;
            if (e == 1) begin
                total++; if ({C7,C6,C5,C4,C3,C2,C1} !== 7'h7F || dp_n !== 1'b1)
                    $display("FAIL scan_blank got %h/%b want 7f/1", {C7,C6,C5,C4,C3,C2,C1}, dp_n); else passed++;
            end
        end
    endtask

    task automatic test_load();
        logic [31:0] v = 32'h0123_4567;
        bit ok;
        do_load(v, 8'hFF, 8'h00);
        total++; if (pending !== 1'b1) $display("FAIL load_pending got %b want 1", pending); else passed++;
        wait_tick(ok);
        total++; if (!ok) $display("FAIL load_timeout got no frame_tick want frame_tick"); else passed++;
        total++; if (pending !== 1'b0) $display("FAIL load_pending_clear got %b want 0", pending); else passed++;
        capture();
        for (int d = 0; d < 8; d++) begin
            total++; if (cap_an[d] !== ~(8'h01 << d)) $display("FAIL load_anode d=%0d got %h want %h", d, cap_an[d], ~(8'h01 << d)); else passed++;
            total++; if (cap_seg[d] !== exp_seg(v[4*d +: 4])) $display("FAIL load_seg d=%0d got %h want %h", d, cap_seg[d], exp_seg(v[4*d +: 4])); else passed++;
            total++; if (cap_dp[d] !== 1'b1) $display("FAIL load_dp d=%0d got %b want 1", d, cap_dp[d]); else passed++;
        end
    endtask

    task automatic test_last_wins();
        bit ok;
        do_load(32'h1111_1111, 8'hFF, 8'h00);
        total++; if (pending !== 1'b1) $display("FAIL lastwins_pending1 got %b want 1", pending); else passed++;
        do_load(32'h2222_2222, 8'hFF, 8'h00);
        total++; if (pending !== 1'b1) $display("FAIL lastwins_pending2 got %b want 1", pending); else passed++;
        wait_tick(ok);
        total++; if (!ok) $display("FAIL lastwins_timeout got no frame_tick want frame_tick"); else passed++;
        total++; if (pending !== 1'b0) $display("FAIL lastwins_pending_clear got %b want 0", pending); else passed++;
        capture();
        for (int d = 0; d < 8; d++) begin
            total++; if (cap_seg[d] !== 7'h24) $display("FAIL lastwins_seg d=%0d got %h want 24", d, cap_seg[d]); else passed++;
        end
    endtask

    // Entered on a frame_tick sample; second load lands exactly on the next boundary.
    task automatic test_boundary_load();
        logic [31:0] a = 32'h89AB_CDEF;
        logic [31:0] b = 32'h7654_3210;
        do_load(a, 8'hFF, 8'h00);
        repeat (30) tick();
        do_load(b, 8'hFF, 8'h80);
        total++; if (frame_tick !== 1'b1) $display("FAIL bload_frame_tick got %b want 1", frame_tick); else passed++;
        total++; if (pending !== 1'b1) $display("FAIL bload_pending got %b want 1", pending); else passed++;
        capture();
        for (int d = 0; d < 8; d++) begin
            total++; if (cap_seg[d] !== exp_seg(a[4*d +: 4])) $display("FAIL bload_old_seg d=%0d got %h want %h", d, cap_seg[d], exp_seg(a[4*d +: 4])); else passed++;
        end
        total++; if (pending !== 1'b0) $display("FAIL bload_pending_clear got %b want 0", pending); else passed++;
        capture();
        for (int d = 0; d < 8; d++) begin
            total++; if (cap_seg[d] !== exp_seg(b[4*d +: 4])) $display("FAIL bload_new_seg d=%0d got %h want %h", d, cap_seg[d], exp_seg(b[4*d +: 4])); else passed++;
            total++; if (cap_dp[d] !== (d != 7)) $display("FAIL bload_dp d=%0d got %b want %b", d, cap_dp[d], (d != 7)); else passed++;
        end
    endtask

    task automatic test_digit_enable();
        logic [31:0] v = 32'h89AB_CDEF;
        logic [6:0]  es;
        bit ok;
        do_load(v, 8'h0F, 8'h01);
        wait_tick(ok);
        total++; if (!ok) $display("FAIL en_timeout got no frame_tick want frame_tick"); else passed++;
        capture();
        for (int d = 0; d < 8; d++) begin
            es = (d >= 4) ? 7'h7F : exp_seg(v[4*d +: 4]);
            total++; if (cap_an[d] !== ~(8'h01 << d)) $display("FAIL en_anode d=%0d got %h want %h", d, cap_an[d], ~(8'h01 << d)); else passed++;
            total++; if (cap_seg[d] !== es) $display("FAIL en_seg d=%0d got %h want %h", d, cap_seg[d], es); else passed++;
            total++; if (cap_dp[d] !== (d != 0)) $display("FAIL en_dp d=%0d got %b want %b", d, cap_dp[d], (d != 0)); else passed++;
        end
    endtask

    task automatic test_leading_zero();
        logic [6:0] es;
        bit ok;
        do_load(32'h0000_00A0, 8'hFF, 8'h00);
        wait_tick(ok);
        total++; if (!ok) $display("FAIL lz_timeout got no frame_tick want frame_tick"); else passed++;
        capture();
        for (int d = 0; d < 8; d++) begin
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
            es = (d == 1) ? 7'h08 : (d == 0) ? 7'h40 : 7'h7F;
`else
            es = (d == 1) ? 7'h08 : 7'h40;
`endif
            total++; if (cap_seg[d] !== es) $display("FAIL lz_seg d=%0d got %h want %h", d, cap_seg[d], es); else passed++;
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_load(32'h5555_5555, 8'hFF, 8'h00);
        total++; if (pending !== 1'b1) $display("FAIL rmid_pending_pre got %b want 1", pending); else passed++;
        rst_n = 1'b0;
        tick();
        total++; if (pending !== 1'b0) $display("FAIL rmid_pending got %b want 0", pending); else passed++;
        total++; if (anode !== 8'hFF) $display("FAIL rmid_anode got %h want ff", anode); else passed++;
        total++; if ({C7,C6,C5,C4,C3,C2,C1} !== 7'h7F) $display("FAIL rmid_seg got %h want 7f", {C7,C6,C5,C4,C3,C2,C1}); else passed++;
        rst_n = 1'b1;
        tick();
        total++; if (anode !== 8'hFE) $display("FAIL rmid_idx0 got %h want fe", anode); else passed++;
        wait_tick(ok);
        total++; if (!ok) $display("FAIL rmid_timeout got no frame_tick want frame_tick"); else passed++;
        total++; if (pending !== 1'b0) $display("FAIL rmid_dropped got %b want 0", pending); else passed++;
        capture();
        for (int d = 0; d < 8; d++) begin
            total++; if (cap_seg[d] !== 7'h7F || cap_dp[d] !== 1'b1)
                $display("FAIL rmid_cleared d=%0d got %h/%b want 7f/1", d, cap_seg[d], cap_dp[d]); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load();
        test_last_wins();
        test_boundary_load();
        test_digit_enable();
        test_leading_zero();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
